// File: rtl/spi_xfer_ctrl.sv
// spi_xfer_ctrl: one-byte SPI mode-0 transfer controller feeding the MOSI shifter
module spi_xfer_ctrl #(
   parameter int DIV_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_start,
   input  logic [7:0]       i_tx_data,
   input  logic [DIV_W-1:0] i_div,
   input  logic             i_cs_assert,
   input  logic             i_cs_hold,
   input  logic             i_miso,
   output logic             o_busy,
   output logic             o_done,
   output logic [7:0]       o_rx_data,
   output logic             o_sclk,
   output logic             o_sclk_q,
   output logic             o_en,
   output logic [7:0]       o_byte_odata,
   output logic             o_cs_n
);
   typedef enum logic [1:0] {IDLE, RUN, TAIL} state_t;
   state_t           r_state, w_next;
   logic [DIV_W-1:0] r_cnt, r_div_l;
   logic [4:0]       r_edges;
   logic [7:0]       r_shift;
   logic             r_hold_l, r_assert_l;
   logic             w_tick, w_accept, w_finish, w_rise;

   // next-state: accept in IDLE, leave RUN after the 16th toggle, finish TAIL on count expiry
   always_comb begin
      w_tick   = (r_cnt == '0);
      w_accept = (r_state == IDLE) && i_start;
      w_finish = (r_state == TAIL) && w_tick;
      w_rise   = o_sclk && !o_sclk_q;
      w_next   = w_accept ? RUN :
                 (r_state == RUN && w_tick && r_edges == 5'd15) ? TAIL :
                 w_finish ? IDLE : r_state;
   end

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   // datapath: divider, sclk generation, MISO capture and chip-select policy
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt        <= '0;
         r_div_l      <= '0;
         r_edges      <= '0;
         r_shift      <= '0;
         r_hold_l     <= 1'b0;
         r_assert_l   <= 1'b0;
         o_busy       <= 1'b0;
         o_done       <= 1'b0;
         o_rx_data    <= '0;
         o_sclk       <= 1'b0;
         o_sclk_q     <= 1'b0;
         o_en         <= 1'b0;
         o_byte_odata <= '0;
         o_cs_n       <= 1'b1;
      end else begin
         o_sclk_q <= o_sclk;
         o_done   <= w_finish;
         if (r_state != IDLE && w_rise) r_shift <= {r_shift[6:0], i_miso};
         if (w_accept) begin
            o_byte_odata <= i_tx_data;
            r_div_l      <= i_div;
            r_hold_l     <= i_cs_hold;
            r_assert_l   <= i_cs_assert;
            o_en         <= 1'b1;
            o_busy       <= 1'b1;
            o_cs_n       <= ~i_cs_assert;
            r_cnt        <= i_div;
            r_edges      <= '0;
            r_shift      <= '0;
         end else if (r_state == RUN) begin
            if (w_tick) begin
               o_sclk  <= ~o_sclk;
               r_cnt   <= r_div_l;
               r_edges <= r_edges + 5'd1;
            end else begin
               r_cnt <= r_cnt - 1'b1;
            end
         end else if (r_state == TAIL) begin
            if (w_tick) begin
               o_en      <= 1'b0;
               o_busy    <= 1'b0;
               o_rx_data <= r_shift;
               o_cs_n    <= ~(r_assert_l & r_hold_l);
            end else begin
               r_cnt <= r_cnt - 1'b1;
            end
         end
      end
   end
endmodule
